// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the hardwired control sequencer: opcode values, FSM states,
// instruction classes and the bit positions of the datapath control bundle.
package control_sequencer_pkg;

  localparam int CTRL_BITS     = 24;
  localparam int CTRL_PCOUT    = 0;
  localparam int CTRL_MAR_EN   = 1;
  localparam int CTRL_INC_PC   = 2;
  localparam int CTRL_ZLOW_IN  = 3;
  localparam int CTRL_ZLOW_OUT = 4;
  localparam int CTRL_PC_EN    = 5;
  localparam int CTRL_MDR_READ = 6;
  localparam int CTRL_MDR_EN   = 7;
  localparam int CTRL_MDR_OUT  = 8;
  localparam int CTRL_IR_EN    = 9;
  localparam int CTRL_GRA      = 10;
  localparam int CTRL_GRB      = 11;
  localparam int CTRL_GRC      = 12;
  localparam int CTRL_BA_OUT   = 13;
  localparam int CTRL_Y_EN     = 14;
  localparam int CTRL_C_OUT    = 15;
  localparam int CTRL_R_IN     = 16;
  localparam int CTRL_R_OUT    = 17;
  localparam int CTRL_RAM_WR   = 18;
  localparam int CTRL_ZHIGH_IN = 19;
  localparam int CTRL_ZHIGH_OUT= 20;
  localparam int CTRL_HI_EN    = 21;
  localparam int CTRL_LO_EN    = 22;
  localparam int CTRL_CON_EN   = 23;

  localparam logic [31:0] OP_LD   = 32'd0;
  localparam logic [31:0] OP_LDI  = 32'd1;
  localparam logic [31:0] OP_ST   = 32'd2;
  localparam logic [31:0] OP_ADD  = 32'd3;   // add..rol occupy 3..11
  localparam logic [31:0] OP_ROL  = 32'd11;
  localparam logic [31:0] OP_ADDI = 32'd12;
  localparam logic [31:0] OP_ANDI = 32'd13;
  localparam logic [31:0] OP_MUL  = 32'd14;
  localparam logic [31:0] OP_DIV  = 32'd15;
  localparam logic [31:0] OP_ORI  = 32'd16;
  localparam logic [31:0] OP_NOP  = 32'd25;
  localparam logic [31:0] OP_HALT = 32'd26;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_LD, CL_LDI, CL_ST, CL_ALU, CL_ALUI, CL_MULDIV, CL_NOP, CL_HALT, CL_ILL
  } op_class_e;

  function automatic op_class_e decode_op(input logic [31:0] op);
    if (op == OP_LD)                     return CL_LD;
    if (op == OP_LDI)                    return CL_LDI;
    if (op == OP_ST)                     return CL_ST;
    if (op >= OP_ADD && op <= OP_ROL)    return CL_ALU;
    if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) return CL_ALUI;
    if (op == OP_MUL || op == OP_DIV)    return CL_MULDIV;
    if (op == OP_NOP)                    return CL_NOP;
    if (op == OP_HALT)                   return CL_HALT;
    return CL_ILL;
  endfunction

endpackage

// File: rtl/control_sequencer_wait_counter.sv
// Memory wait counter: cleared whenever the sequencer is not waiting on memory,
// counts each stalled cycle, and flags the cycle in which the wait budget is used up.
module seq_wait_counter #(
  parameter int WAIT_MAX = 15
) (
  input  logic Clock,
  input  logic Clear,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CNT_W = $clog2(WAIT_MAX + 2);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch T0..T2, decode in T3, execute up to T7,
// with Mem_ready stalls, run/idle control, halt and memory-timeout handling.
import control_sequencer_pkg::*;

module control_sequencer #(
  parameter int OPCODE_W = 5,
  parameter int STEP_W   = 4,
  parameter int CTRL_W   = 24,
  parameter int WAIT_MAX = 15
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Run,
  input  logic [OPCODE_W-1:0] IR_opcode,
  input  logic                Mem_ready,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic [STEP_W-1:0]   step_o,
  output logic                Halted,
  output logic                Illegal_op,
  output logic                Mem_timeout
);

  state_e    state, state_nx, done_nx;
  op_class_e cls, cls_nx;
  logic      mem_step, mem_wait, at_limit, timeout_now;

  seq_wait_counter #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .Clock    (Clock),
    .Clear    (Clear),
    .clr      (!mem_wait),
    .inc      (mem_wait),
    .at_limit (at_limit)
  );

  function automatic logic [CTRL_BITS-1:0] ctrl_rom(input state_e s, input op_class_e c,
                                                    input logic first);
    logic [CTRL_BITS-1:0] b;
    b = '0;
    case (s)
      S_T0: begin
        b[CTRL_PCOUT] = 1'b1; b[CTRL_MAR_EN] = 1'b1;
        b[CTRL_INC_PC] = 1'b1; b[CTRL_ZLOW_IN] = 1'b1;
      end
      S_T1: begin
        b[CTRL_ZLOW_OUT] = 1'b1; b[CTRL_PC_EN] = first;
        b[CTRL_MDR_READ] = 1'b1; b[CTRL_MDR_EN] = 1'b1;
      end
      S_T2: begin
        b[CTRL_MDR_OUT] = 1'b1; b[CTRL_IR_EN] = 1'b1;
      end
      S_T3: begin
        case (c)
          CL_LD, CL_LDI, CL_ST: begin
            b[CTRL_GRB] = 1'b1; b[CTRL_BA_OUT] = 1'b1; b[CTRL_Y_EN] = 1'b1;
          end
          CL_ALU, CL_ALUI, CL_MULDIV: begin
            b[CTRL_GRB] = 1'b1; b[CTRL_R_OUT] = 1'b1; b[CTRL_Y_EN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        b[CTRL_ZLOW_IN] = 1'b1;
        b[CTRL_ZHIGH_IN] = (c == CL_MULDIV);
        // Register-register forms read Rc; immediate and address forms take C.
        if (c == CL_ALU || c == CL_MULDIV) begin
          b[CTRL_GRC] = 1'b1; b[CTRL_R_OUT] = 1'b1;
        end else begin
          b[CTRL_C_OUT] = 1'b1;
        end
      end
      S_T5: begin
        b[CTRL_ZLOW_OUT] = 1'b1;
        case (c)
          CL_LD, CL_ST: b[CTRL_MAR_EN] = 1'b1;
          CL_MULDIV:    b[CTRL_LO_EN] = 1'b1;
          default: begin
            b[CTRL_GRA] = 1'b1; b[CTRL_R_IN] = 1'b1;
          end
        endcase
      end
      S_T6: begin
        case (c)
          CL_LD: begin
            b[CTRL_MDR_READ] = 1'b1; b[CTRL_MDR_EN] = 1'b1;
          end
          CL_ST: begin
            b[CTRL_GRA] = 1'b1; b[CTRL_R_OUT] = 1'b1; b[CTRL_MDR_EN] = 1'b1;
          end
          default: begin
            b[CTRL_ZHIGH_OUT] = 1'b1; b[CTRL_HI_EN] = 1'b1;
          end
        endcase
      end
      S_T7: begin
        if (c == CL_ST) begin
          b[CTRL_RAM_WR] = 1'b1;
        end else begin
          b[CTRL_MDR_OUT] = 1'b1; b[CTRL_GRA] = 1'b1; b[CTRL_R_IN] = 1'b1;
        end
      end
      default: ;
    endcase
    return b;
  endfunction

  function automatic logic [3:0] step_of(input state_e s);
    if (s >= S_T0 && s <= S_T7) return 4'(s - S_T0);
    return 4'd0;
  endfunction

  // IR is loaded on the edge leaving T2, so the opcode is captured on that same edge
  // and T3's registered controls already reflect the decoded instruction.
  always_comb begin
    cls_nx      = (state == S_T2) ? decode_op(32'(IR_opcode)) : cls;
    mem_step    = (state == S_T1) || (state == S_T6 && cls == CL_LD) ||
                  (state == S_T7 && cls == CL_ST);
    mem_wait    = mem_step && !Mem_ready;
    timeout_now = mem_wait && at_limit;
    done_nx     = Run ? S_T0 : S_IDLE;

    state_nx = state;
    case (state)
      S_IDLE: if (Run) state_nx = S_T0;
      S_T0:   state_nx = S_T1;
      S_T1:   if (!mem_wait) state_nx = S_T2;
      S_T2:   state_nx = S_T3;
      S_T3: begin
        case (cls)
          CL_HALT:        state_nx = S_HALT;
          CL_NOP, CL_ILL: state_nx = done_nx;
          default:        state_nx = S_T4;
        endcase
      end
      S_T4:   state_nx = S_T5;
      S_T5: begin
        if (cls == CL_LD || cls == CL_ST || cls == CL_MULDIV) state_nx = S_T6;
        else state_nx = done_nx;
      end
      S_T6: begin
        if (cls == CL_MULDIV) state_nx = done_nx;
        else if (!mem_wait)   state_nx = S_T7;
      end
      S_T7:   if (!mem_wait) state_nx = done_nx;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
    if (timeout_now) state_nx = S_HALT;
  end

  // Outputs are registered from the next state so they only change on the clock edge.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state       <= S_IDLE;
      cls         <= CL_NOP;
      ctrl_o      <= '0;
      step_o      <= '0;
      Halted      <= 1'b0;
      Illegal_op  <= 1'b0;
      Mem_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      cls         <= cls_nx;
      ctrl_o      <= CTRL_W'(ctrl_rom(state_nx, cls_nx, state != S_T1));
      step_o      <= STEP_W'(step_of(state_nx));
      Halted      <= (state_nx == S_HALT);
      Illegal_op  <= (state == S_T2) && (cls_nx == CL_ILL);
      if (timeout_now) Mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle stimulus and expected outputs are produced by an
// instruction-level model; a monitor compares the DUT against the queued expectations.
module tb_control_sequencer;

  localparam int WAIT_MAX = 15;

  localparam int B_PCOUT = 0,  B_MAR = 1,  B_INCPC = 2, B_ZLIN = 3,  B_ZLOUT = 4,  B_PCEN = 5;
  localparam int B_MDRRD = 6,  B_MDREN = 7, B_MDROUT = 8, B_IREN = 9, B_GRA = 10, B_GRB = 11;
  localparam int B_GRC = 12, B_BAOUT = 13, B_YEN = 14, B_COUT = 15, B_RIN = 16, B_ROUT = 17;
  localparam int B_RAMWR = 18, B_ZHIN = 19, B_ZHOUT = 20, B_HIEN = 21, B_LOEN = 22;

  localparam int M_RUN = 0, M_IDLE = 1, M_HALT = 2, M_RESET = 3;

  typedef struct packed {
    logic        clr_n;
    logic        run;
    logic [4:0]  op;
    logic        rdy;
    logic [23:0] ctrl;
    logic [3:0]  step;
    logic        halted;
    logic        ill;
    logic        to;
  } rec_t;

  logic        Clock, Clear, Run, Mem_ready;
  logic [4:0]  IR_opcode;
  logic [23:0] ctrl_o;
  logic [3:0]  step_o;
  logic        Halted, Illegal_op, Mem_timeout;

  rec_t        stim_q[$];
  logic [30:0] sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          mode  = M_RESET;
  bit          to_flag = 0;
  bit          gen_done = 0;
  bit          drv_done = 0;

  control_sequencer #(.OPCODE_W(5), .STEP_W(4), .CTRL_W(24), .WAIT_MAX(WAIT_MAX)) dut (
    .Clock       (Clock),
    .Clear       (Clear),
    .Run         (Run),
    .IR_opcode   (IR_opcode),
    .Mem_ready   (Mem_ready),
    .ctrl_o      (ctrl_o),
    .step_o      (step_o),
    .Halted      (Halted),
    .Illegal_op  (Illegal_op),
    .Mem_timeout (Mem_timeout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [23:0] bm(input int i);
    return 24'd1 << i;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic emit(input logic clr_n, input logic run, input logic [4:0] op, input logic rdy,
                      input logic [23:0] ctrl, input int step, input logic halted,
                      input logic ill, input logic to);
    rec_t r;
    r.clr_n = clr_n; r.run = run; r.op = op; r.rdy = rdy;
    r.ctrl = ctrl; r.step = 4'(step); r.halted = halted; r.ill = ill; r.to = to;
    stim_q.push_back(r);
  endtask

  task automatic gen_reset(input int n);
    for (int i = 0; i < n; i++) emit(1'b0, rb(), 5'($urandom), rb(), '0, 0, 1'b0, 1'b0, 1'b0);
    mode = M_IDLE; to_flag = 0;
  endtask

  task automatic gen_idle(input int n);
    for (int i = 0; i < n; i++) emit(1'b1, 1'b0, 5'($urandom), rb(), '0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic gen_start();
    emit(1'b1, 1'b1, 5'($urandom), rb(), '0, 0, 1'b0, 1'b0, 1'b0);
    mode = M_RUN;
  endtask

  task automatic gen_halt(input int n);
    for (int i = 0; i < n; i++) emit(1'b1, rb(), 5'($urandom), rb(), '0, 0, 1'b1, 1'b0, to_flag);
  endtask

  // One instruction from T0: the control word of each step comes from the opcode's
  // register-transfer recipe; memory steps last wait+1 cycles, Mem_ready on the last.
  task automatic gen_instr(input logic [4:0] op, input int w1, input int wm,
                           input bit run_after, input int abort_step);
    logic [23:0] m[$];
    logic [23:0] c;
    logic [4:0]  drv_op;
    int          memstep, w;
    bit          ill, hlt, last;
    memstep = -1; ill = 0; hlt = 0;
    m.push_back(bm(B_PCOUT) | bm(B_MAR) | bm(B_INCPC) | bm(B_ZLIN));
    m.push_back(bm(B_ZLOUT) | bm(B_PCEN) | bm(B_MDRRD) | bm(B_MDREN));
    m.push_back(bm(B_MDROUT) | bm(B_IREN));
    if (op <= 5'd2) begin
      m.push_back(bm(B_GRB) | bm(B_BAOUT) | bm(B_YEN));
      m.push_back(bm(B_COUT) | bm(B_ZLIN));
      if (op == 5'd1) m.push_back(bm(B_ZLOUT) | bm(B_GRA) | bm(B_RIN));
      else begin
        m.push_back(bm(B_ZLOUT) | bm(B_MAR));
        if (op == 5'd0) begin
          m.push_back(bm(B_MDRRD) | bm(B_MDREN));
          m.push_back(bm(B_MDROUT) | bm(B_GRA) | bm(B_RIN));
          memstep = 6;
        end else begin
          m.push_back(bm(B_GRA) | bm(B_ROUT) | bm(B_MDREN));
          m.push_back(bm(B_RAMWR));
          memstep = 7;
        end
      end
    end else if (op inside {[5'd3:5'd11], 5'd12, 5'd13, 5'd16}) begin
      m.push_back(bm(B_GRB) | bm(B_ROUT) | bm(B_YEN));
      if (op inside {5'd12, 5'd13, 5'd16}) m.push_back(bm(B_COUT) | bm(B_ZLIN));
      else m.push_back(bm(B_GRC) | bm(B_ROUT) | bm(B_ZLIN));
      m.push_back(bm(B_ZLOUT) | bm(B_GRA) | bm(B_RIN));
    end else if (op inside {5'd14, 5'd15}) begin
      m.push_back(bm(B_GRB) | bm(B_ROUT) | bm(B_YEN));
      m.push_back(bm(B_GRC) | bm(B_ROUT) | bm(B_ZLIN) | bm(B_ZHIN));
      m.push_back(bm(B_ZLOUT) | bm(B_LOEN));
      m.push_back(bm(B_ZHOUT) | bm(B_HIEN));
    end else begin
      m.push_back('0);
      hlt = (op == 5'd26);
      ill = (op != 5'd25) && !hlt;
    end
    for (int s = 0; s < m.size(); s++) begin
      if (s == abort_step) begin
        emit(1'b0, rb(), 5'($urandom), rb(), '0, 0, 1'b0, 1'b0, 1'b0);
        mode = M_RESET; to_flag = 0;
        return;
      end
      drv_op = (s == 2 || s == 3) ? op : 5'($urandom);
      last = (s == m.size() - 1);
      if (s == 1 || s == memstep) begin
        w = (s == 1) ? w1 : wm;
        for (int k = 0; k <= WAIT_MAX; k++) begin
          c = m[s];
          if (s == 1 && k > 0) c = c & ~bm(B_PCEN);
          emit(1'b1, (last && k == w) ? run_after : rb(), drv_op, (k == w), c, s,
               1'b0, 1'b0, 1'b0);
          if (k == w) break;
        end
        if (w > WAIT_MAX) begin
          mode = M_HALT; to_flag = 1;
          return;
        end
      end else begin
        emit(1'b1, last ? run_after : rb(), drv_op, rb(), m[s], s, 1'b0,
             (s == 3) && ill, 1'b0);
      end
    end
    to_flag = 0;
    mode = hlt ? M_HALT : (run_after ? M_RUN : M_IDLE);
  endtask

  // Bring the model back to a running state at T0 whatever the last instruction left.
  task automatic recover();
    if (mode == M_HALT) begin gen_halt(3); gen_reset(2); end
    else if (mode == M_RESET) gen_reset(1);
    if (mode == M_IDLE) begin gen_idle($urandom_range(0, 2)); gen_start(); end
  endtask

  initial begin : driver
    rec_t r;
    Clear = 1'b0; Run = 1'b0; IR_opcode = '0; Mem_ready = 1'b0;
    wait (gen_done);
    while (stim_q.size() > 0) begin
      @(posedge Clock); #1;
      r = stim_q.pop_front();
      Clear = r.clr_n; Run = r.run; IR_opcode = r.op; Mem_ready = r.rdy;
      sb_q.push_back({r.ctrl, r.step, r.halted, r.ill, r.to});
    end
    drv_done = 1;
  end

  always @(negedge Clock) begin : monitor
    logic [30:0] exp_v, act_v;
    cyc++;
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      act_v = {ctrl_o, step_o, Halted, Illegal_op, Mem_timeout};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle%0d: got ctrl=%h step=%0d halt=%b ill=%b to=%b, want ctrl=%h step=%0d halt=%b ill=%b to=%b",
                 cyc, act_v[30:7], act_v[6:3], act_v[2], act_v[1], act_v[0],
                 exp_v[30:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin : main
    logic [4:0] ops[$];
    logic [4:0] op;
    int         w1, wm;
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd11, 5'd12, 5'd13, 5'd14,
            5'd15, 5'd16, 5'd25, 5'd26, 5'd31, 5'd20};

    gen_reset(3); gen_idle(2); gen_start();
    gen_instr(5'd0, 0, 0, 1'b1, -1);                     // ld, zero wait
    gen_instr(5'd0, 3, 3, 1'b1, -1);                     // ld, 3-cycle waits
    gen_instr(5'd2, 0, 2, 1'b0, -1);                     // st, then drop to idle
    gen_idle(3); gen_start();
    gen_instr(5'd3, 0, 0, 1'b1, -1);                     // add then halt
    gen_instr(5'd26, 1, 0, 1'b1, -1);
    gen_halt(20); gen_reset(2); gen_start();
    gen_instr(5'd31, 0, 0, 1'b1, -1);                    // illegal opcode
    gen_instr(5'd14, 0, 0, 1'b1, -1);
    gen_instr(5'd15, 2, 0, 1'b1, -1);
    gen_instr(5'd12, 0, 0, 1'b1, -1);
    gen_instr(5'd16, 0, 0, 1'b1, -1);
    gen_instr(5'd25, 0, 0, 1'b1, -1);
    gen_instr(5'd1, 1, 0, 1'b1, -1);
    gen_instr(5'd0, WAIT_MAX, WAIT_MAX, 1'b1, -1);       // last legal wait cycle
    gen_instr(5'd2, 0, WAIT_MAX, 1'b1, -1);
    gen_instr(5'd0, 0, WAIT_MAX + 1, 1'b1, -1);          // ld times out in T6
    recover();
    gen_instr(5'd3, 0, 0, 1'b1, 4);                      // Clear during T4
    recover();
    gen_instr(5'd2, WAIT_MAX + 1, 0, 1'b1, -1);          // T1 times out
    recover();

    for (int i = 0; i < 50; i++) begin
      op = ops[$urandom_range(0, ops.size() - 1)];
      w1 = ($urandom_range(0, 9) == 0) ? $urandom_range(WAIT_MAX - 1, WAIT_MAX + 1)
                                      : $urandom_range(0, 3);
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(WAIT_MAX - 1, WAIT_MAX + 1)
                                      : $urandom_range(0, 3);
      gen_instr(op, w1, wm, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 11) == 0) ? $urandom_range(1, 3) : -1);
      recover();
    end
    gen_halt(0);
    gen_done = 1;

    for (int i = 0; i < 60000 && !drv_done; i++) @(posedge Clock);
    if (!drv_done) begin
      $display("FAIL run_bound: driver still busy, %0d records left, want 0", stim_q.size());
      $fatal(1, "bench did not drain its stimulus");
    end
    @(negedge Clock); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
